// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and index/data typedefs for the scoreboarded register file.
// Combinational/type-only content; no timing or backpressure implications.
package regfile_pkg;

  localparam int DEF_DW   = 16;
  localparam int DEF_NREG = 16;
  localparam int DEF_NRP  = 2;
  localparam int DEF_AW   = $clog2(DEF_NREG);

  typedef logic [DEF_AW-1:0] reg_idx_t;
  typedef logic [DEF_DW-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode-stage bus of the register file: read ports, writeback and issue.
// Reads are zero-latency; there is no backpressure, every enable is accepted.
interface reg_file_sb_if #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int NRP  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRP*AW-1:0] rd_idx;
  logic [NRP*DW-1:0] rd_data;
  logic [NRP-1:0]    rd_busy;
  logic              wb_en;
  logic [AW-1:0]     wb_idx;
  logic [DW-1:0]     wb_data;
  logic              iss_en;
  logic [AW-1:0]     iss_idx;
  logic              any_busy;

  modport master (
    output rd_idx, wb_en, wb_idx, wb_data, iss_en, iss_idx,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_idx, wb_en, wb_idx, wb_data, iss_en, iss_idx,
    output rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/reg_file_sb_rdport.sv
// One read port: storage mux plus optional writeback forwarding (REGFILE_BYPASS_EN).
// Zero latency, purely combinational; no backpressure.
module reg_file_sb_rdport #(
  parameter int DW       = 16,
  parameter int NREG     = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 0
) (
  input  logic [AW-1:0]            idx,
  input  logic [NREG-1:0][DW-1:0]  mem,
  input  logic [NREG-1:0]          pend,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_idx,
  input  logic [DW-1:0]            wb_data,
  output logic [DW-1:0]            data,
  output logic                     busy
);

  logic is_zero;

  always_comb begin
    is_zero = (ZERO_REG != 0) && (idx == '0);
    data    = mem[idx];
    busy    = pend[idx];
`ifdef REGFILE_BYPASS_EN
    // A writeback landing this cycle is the freshest value; a same-cycle
    // re-issue only shows up as busy once it has been registered.
    if (wb_en && (idx == wb_idx)) begin
      data = wb_data;
      busy = 1'b0;
    end
`endif
    if (is_zero) begin
      data = '0;
      busy = 1'b0;
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_idx, wb_data};
`endif

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register pending scoreboard; REGFILE_BYPASS_EN adds wb forwarding.
// Reads zero latency, writes/pending visible next cycle; no backpressure.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int NREG     = DEF_NREG,
  parameter int NRP      = DEF_NRP,
  parameter int ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  logic [NREG-1:0][DW-1:0] mem;
  logic [NREG-1:0]         pend;
  logic                    wb_ok;
  logic                    iss_ok;
  logic [NRP-1:0][DW-1:0]  rdata;
  logic [NRP-1:0]          rbusy;

  assign wb_ok  = bus.wb_en  && !((ZERO_REG != 0) && (bus.wb_idx  == '0));
  assign iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_idx == '0));

  // Issue is applied after writeback so a same-index collision leaves the
  // register pending for the newer producer while still taking the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem  <= '0;
      pend <= '0;
    end else begin
      if (wb_ok) begin
        mem[bus.wb_idx]  <= bus.wb_data;
        pend[bus.wb_idx] <= 1'b0;
      end
      if (iss_ok) begin
        pend[bus.iss_idx] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    reg_file_sb_rdport #(
      .DW       (DW),
      .NREG     (NREG),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .idx     (bus.rd_idx[p*AW +: AW]),
      .mem     (mem),
      .pend    (pend),
      .wb_en   (wb_ok),
      .wb_idx  (bus.wb_idx),
      .wb_data (bus.wb_data),
      .data    (rdata[p]),
      .busy    (rbusy[p])
    );
  end

  assign bus.rd_data  = rdata;
  assign bus.rd_busy  = rbusy;
  assign bus.any_busy = |pend;

endmodule
